// File: rtl/pmem_arbiter_if.sv
// Bundle of every cache-side and memory-side signal around pmem_arbiter.
// The arbiter connects through the slave modport; the master modport is
// the combined view of the I-cache, D-cache and cacheline adaptor.
interface pmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              icache_read;
  logic [ADDR_W-1:0] icache_addr;
  logic [LINE_W-1:0] icache_rdata;
  logic              icache_resp;

  logic              dcache_read;
  logic              dcache_write;
  logic [ADDR_W-1:0] dcache_addr;
  logic [LINE_W-1:0] dcache_wdata;
  logic [LINE_W-1:0] dcache_rdata;
  logic              dcache_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  logic              busy;

  modport slave (
    input  icache_read, icache_addr,
    input  dcache_read, dcache_write, dcache_addr, dcache_wdata,
    input  pmem_rdata, pmem_resp,
    output icache_rdata, icache_resp,
    output dcache_rdata, dcache_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    output busy
  );

  modport master (
    output icache_read, icache_addr,
    output dcache_read, dcache_write, dcache_addr, dcache_wdata,
    output pmem_rdata, pmem_resp,
    input  icache_rdata, icache_resp,
    input  dcache_rdata, dcache_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  busy
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Shares the single physical-memory port between the I-cache and D-cache.
// One whole-line transaction at a time; the winner's command is latched at
// grant and held until pmem_resp, and the response is routed to it alone.
// Optional feature: define PMEM_ARB_RR_EN to alternate grants between I
// and D on contention; otherwise D always beats I.
module pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic          clk,
  input  logic          rst,
  pmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              lock_q, lock_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
`ifdef PMEM_ARB_RR_EN
  logic              last_d_q, last_d_d;
`endif

  logic d_req;
  logic i_req;
  logic grant_d;
  logic serving;

  // Decide who would win if a grant were made this cycle
  always_comb begin
    d_req   = bus.dcache_read | bus.dcache_write;
    i_req   = bus.icache_read;
    grant_d = 1'b0;
    if (lock_q && bus.dcache_read) begin
      grant_d = 1'b1;
    end else if (d_req && i_req) begin
`ifdef PMEM_ARB_RR_EN
      grant_d = ~last_d_q;
`else
      grant_d = 1'b1;
`endif
    end else begin
      grant_d = d_req;
    end
  end

  // Next-state logic: grant and latch in IDLE, return to IDLE on pmem_resp
  always_comb begin
    state_d  = state_q;
    read_d   = read_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    lock_d   = 1'b0;
`ifdef PMEM_ARB_RR_EN
    last_d_d = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (d_req || i_req) begin
          if (grant_d) begin
            state_d  = SERVE_D;
            write_d  = bus.dcache_write;
            read_d   = ~bus.dcache_write;
            addr_d   = bus.dcache_addr;
            wdata_d  = bus.dcache_wdata;
`ifdef PMEM_ARB_RR_EN
            last_d_d = 1'b1;
`endif
          end else begin
            state_d  = SERVE_I;
            write_d  = 1'b0;
            read_d   = 1'b1;
            addr_d   = bus.icache_addr;
            wdata_d  = '0;
`ifdef PMEM_ARB_RR_EN
            last_d_d = 1'b0;
`endif
          end
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.pmem_resp) begin
          state_d = IDLE;
          lock_d  = (state_q == SERVE_D) && write_q;
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  // State and latched-command registers, cleared immediately on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      lock_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
`ifdef PMEM_ARB_RR_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      read_q   <= read_d;
      write_q  <= write_d;
      lock_q   <= lock_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
`ifdef PMEM_ARB_RR_EN
      last_d_q <= last_d_d;
`endif
    end
  end

  // Drive the memory command from the latches and route the response back
  always_comb begin
    serving          = (state_q != IDLE);
    bus.busy         = serving;
    bus.pmem_read    = serving & read_q;
    bus.pmem_write   = serving & write_q;
    bus.pmem_address = serving ? addr_q : '0;
    bus.pmem_wdata   = serving ? wdata_q : '0;
    bus.icache_resp  = (state_q == SERVE_I) & bus.pmem_resp & bus.icache_read;
    bus.dcache_resp  = (state_q == SERVE_D) & bus.pmem_resp & d_req;
    bus.icache_rdata = bus.icache_resp ? bus.pmem_rdata : '0;
    bus.dcache_rdata = bus.dcache_resp ? bus.pmem_rdata : '0;
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Testbench for pmem_arbiter: directed arbitration scenarios followed by
// randomized I/D traffic. A line-memory reference model predicts read data
// per requester; a monitor pops the expectations whenever a cache sees its
// response, and the adaptor model checks every memory command it receives.
module tb_pmem_arbiter;

  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 256;
  localparam int MAX_WAIT = 300;

  typedef struct {
    bit               is_write;
    logic [LINE_W-1:0] data;
  } d_exp_t;

  typedef struct {
    bit               rd;
    bit               wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } cmd_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pmem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [LINE_W-1:0] i_exp [$];
  d_exp_t            d_exp [$];
  cmd_t              cmd_exp [$];
  logic [LINE_W-1:0] ref_mem  [logic [ADDR_W-1:0]];
  logic [LINE_W-1:0] phys_mem [logic [ADDR_W-1:0]];

  int checks  = 0;
  int errors  = 0;
  bit rand_phase = 1'b0;
  bit strict_cmd = 1'b0;
  int lat_min = 2;
  int lat_max = 4;

  // Contents of a line that has never been written
  function automatic logic [LINE_W-1:0] init_line(input logic [ADDR_W-1:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  function automatic logic [LINE_W-1:0] ref_line(input logic [ADDR_W-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_line(a);
  endfunction

  function automatic logic [LINE_W-1:0] phys_line(input logic [ADDR_W-1:0] a);
    if (phys_mem.exists(a)) return phys_mem[a];
    return init_line(a);
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic check_output(input string name, input logic [LINE_W-1:0] act,
                              input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout, expected event within %0d cycles", name, MAX_WAIT);
  endtask

  function automatic void push_cmd(input bit rd, input bit wr,
                                   input logic [ADDR_W-1:0] a,
                                   input logic [LINE_W-1:0] wd);
    cmd_t c;
    c.rd = rd; c.wr = wr; c.addr = a; c.wdata = wd;
    cmd_exp.push_back(c);
  endfunction

  // Monitor: response exclusivity, idle rdata, and scoreboard pops
  always @(negedge clk) begin : monitor
    logic [LINE_W-1:0] e;
    d_exp_t de;
    if (rst) begin
      check_output("resp_exclusive", LINE_W'(bus.icache_resp & bus.dcache_resp), '0);
      if (!bus.icache_resp) check_output("icache_rdata_idle", bus.icache_rdata, '0);
      if (!bus.dcache_resp) check_output("dcache_rdata_idle", bus.dcache_rdata, '0);
      if (bus.icache_resp) begin
        if (i_exp.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL icache_resp_spurious: got resp=1, expected resp=0");
        end else begin
          e = i_exp.pop_front();
          check_output("icache_rdata", bus.icache_rdata, e);
        end
      end
      if (bus.dcache_resp) begin
        if (d_exp.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL dcache_resp_spurious: got resp=1, expected resp=0");
        end else begin
          de = d_exp.pop_front();
          if (!de.is_write) check_output("dcache_rdata", bus.dcache_rdata, de.data);
        end
      end
    end
  end

  // Cacheline adaptor model: checks commands, holds them for a random latency
  initial begin : adaptor
    cmd_t c, e;
    int   lat;
    bit   aborted;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst && (bus.pmem_read || bus.pmem_write)) begin
        c.rd = bus.pmem_read; c.wr = bus.pmem_write;
        c.addr = bus.pmem_address; c.wdata = bus.pmem_wdata;
        if (cmd_exp.size() > 0) begin
          e = cmd_exp.pop_front();
          check_output("pmem_op", LINE_W'({c.rd, c.wr}), LINE_W'({e.rd, e.wr}));
          check_output("pmem_address", LINE_W'(c.addr), LINE_W'(e.addr));
          if (e.wr) check_output("pmem_wdata", c.wdata, e.wdata);
        end else if (strict_cmd) begin
          checks++; errors++;
          $display("[TB] FAIL pmem_cmd_unexpected: got addr %h, expected no command", c.addr);
        end
        lat = $urandom_range(lat_max, lat_min);
        aborted = 1'b0;
        for (int k = 0; k < lat; k++) begin
          @(negedge clk);
          if (!rst) begin
            aborted = 1'b1;
            break;
          end
          check_output("pmem_op_stable", LINE_W'({bus.pmem_read, bus.pmem_write}),
                       LINE_W'({c.rd, c.wr}));
          check_output("pmem_addr_stable", LINE_W'(bus.pmem_address), LINE_W'(c.addr));
          check_output("pmem_wdata_stable", bus.pmem_wdata, c.wdata);
        end
        if (!aborted) begin
          @(posedge clk); #1;
          bus.pmem_rdata = c.wr ? rand_line() : phys_line(c.addr);
          if (c.wr) phys_mem[c.addr] = c.wdata;
          bus.pmem_resp = 1'b1;
          @(negedge clk);
          check_output("pmem_op_at_resp", LINE_W'({bus.pmem_read, bus.pmem_write}),
                       LINE_W'({c.rd, c.wr}));
          @(posedge clk); #1;
          bus.pmem_resp  = 1'b0;
          bus.pmem_rdata = '0;
        end
      end else if (rand_phase && rst && $urandom_range(7, 0) == 0) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = rand_line();
        @(posedge clk); #1;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
      end
    end
  end

  task automatic i_request(input logic [ADDR_W-1:0] addr);
    int n = 0;
    @(posedge clk); #1;
    bus.icache_read = 1'b1;
    bus.icache_addr = addr;
    i_exp.push_back(ref_line(addr));
    do begin
      @(negedge clk);
      n++;
    end while (!bus.icache_resp && n < MAX_WAIT);
    if (!bus.icache_resp) fail_now("icache_timeout");
  endtask

  task automatic d_request(input bit wr, input logic [ADDR_W-1:0] addr,
                           input logic [LINE_W-1:0] data);
    int n = 0;
    d_exp_t de;
    @(posedge clk); #1;
    bus.dcache_write = wr;
    bus.dcache_read  = ~wr;
    bus.dcache_addr  = addr;
    bus.dcache_wdata = wr ? data : rand_line();
    de.is_write = wr;
    if (wr) begin
      ref_mem[addr] = data;
      de.data = '0;
    end else begin
      de.data = ref_line(addr);
    end
    d_exp.push_back(de);
    do begin
      @(negedge clk);
      n++;
    end while (!bus.dcache_resp && n < MAX_WAIT);
    if (!bus.dcache_resp) fail_now("dcache_timeout");
  endtask

  task automatic i_release();
    @(posedge clk); #1;
    bus.icache_read = 1'b0;
  endtask

  task automatic d_release();
    @(posedge clk); #1;
    bus.dcache_read  = 1'b0;
    bus.dcache_write = 1'b0;
  endtask

  task automatic wait_pmem_cmd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.pmem_read || bus.pmem_write) && n < MAX_WAIT);
    if (!(bus.pmem_read || bus.pmem_write)) fail_now("pmem_cmd_timeout");
  endtask

  task automatic wait_pmem_resp();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.pmem_resp && n < MAX_WAIT);
    if (!bus.pmem_resp) fail_now("pmem_resp_timeout");
  endtask

  // Directed scenarios from the block's behaviour, then random traffic
  task automatic apply_stimulus();
    logic [LINE_W-1:0] x;

    // Asynchronous reset in the middle of a D writeback
    push_cmd(1'b0, 1'b1, 32'h0000_0800, 256'h1234);
    @(posedge clk); #1;
    bus.dcache_write = 1'b1;
    bus.dcache_addr  = 32'h0000_0800;
    bus.dcache_wdata = 256'h1234;
    wait_pmem_cmd();
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_output("reset_pmem_write", LINE_W'(bus.pmem_write), '0);
    check_output("reset_busy", LINE_W'(bus.busy), '0);
    check_output("reset_pmem_address", LINE_W'(bus.pmem_address), '0);
    repeat (2) @(negedge clk);
    #1;
    bus.dcache_write = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_output("post_reset_busy", LINE_W'(bus.busy), '0);

    // Lone I read with latency and data routing checks
    phys_mem[32'h0000_0060] = {32{8'hA5}};
    ref_mem[32'h0000_0060]  = {32{8'hA5}};
    push_cmd(1'b1, 1'b0, 32'h0000_0060, '0);
    i_request(32'h0000_0060);
    i_release();
    @(negedge clk);
    check_output("lone_i_busy_after", LINE_W'(bus.busy), '0);

    @(posedge clk); #1;
    bus.icache_read = 1'b1;
    bus.icache_addr = 32'h0000_0060;
    i_exp.push_back(ref_line(32'h0000_0060));
    push_cmd(1'b1, 1'b0, 32'h0000_0060, '0);
    @(negedge clk);
    check_output("latency_cycle_n", LINE_W'(bus.pmem_read), '0);
    @(negedge clk);
    check_output("latency_cycle_n1", LINE_W'(bus.pmem_read), 256'd1);
    check_output("latency_addr", LINE_W'(bus.pmem_address), 256'h60);
    wait_pmem_resp();
    check_output("lone_i_resp", LINE_W'(bus.icache_resp), 256'd1);
    check_output("lone_i_rdata", bus.icache_rdata, {32{8'hA5}});
    check_output("lone_i_no_dresp", LINE_W'(bus.dcache_resp), '0);
    i_release();
    @(negedge clk);
    check_output("lone_i_busy_low", LINE_W'(bus.busy), '0);

    // Contention: D first; second contention depends on mode
    push_cmd(1'b0, 1'b0, 32'h0, '0);
    void'(cmd_exp.pop_back());
    push_cmd(1'b1, 1'b0, 32'h0000_0200, '0);
`ifdef PMEM_ARB_RR_EN
    push_cmd(1'b1, 1'b0, 32'h0000_0100, '0);
    push_cmd(1'b1, 1'b0, 32'h0000_0240, '0);
`else
    push_cmd(1'b1, 1'b0, 32'h0000_0240, '0);
    push_cmd(1'b1, 1'b0, 32'h0000_0100, '0);
`endif
    fork
      begin i_request(32'h0000_0100); i_release(); end
      begin d_request(1'b0, 32'h0000_0200, '0); d_request(1'b0, 32'h0000_0240, '0); d_release(); end
    join

    // Writeback lock: D write then D read stay atomic against a pending I
    x = rand_line();
    push_cmd(1'b0, 1'b1, 32'h0000_0300, x);
    push_cmd(1'b1, 1'b0, 32'h0000_0400, '0);
    push_cmd(1'b1, 1'b0, 32'h0000_0180, '0);
    fork
      begin d_request(1'b1, 32'h0000_0300, x); d_request(1'b0, 32'h0000_0400, '0); d_release(); end
      begin wait_pmem_cmd(); i_request(32'h0000_0180); i_release(); end
    join

    // Request inputs change while granted; latched values must persist
    x = rand_line();
    push_cmd(1'b0, 1'b1, 32'h0000_0500, x);
    fork
      begin d_request(1'b1, 32'h0000_0500, x); d_release(); end
      begin
        wait_pmem_cmd();
        @(posedge clk); #1;
        bus.dcache_addr  = 32'hDEAD_0000;
        bus.dcache_wdata = rand_line();
      end
    join

    // I drops its request mid-transaction; command held, no resp to I
    push_cmd(1'b1, 1'b0, 32'h0000_0700, '0);
    @(posedge clk); #1;
    bus.icache_read = 1'b1;
    bus.icache_addr = 32'h0000_0700;
    wait_pmem_cmd();
    @(posedge clk); #1;
    bus.icache_read = 1'b0;
    wait_pmem_resp();
    check_output("drop_pmem_read_held", LINE_W'(bus.pmem_read), 256'd1);
    check_output("drop_icache_resp", LINE_W'(bus.icache_resp), '0);
    @(negedge clk);
    check_output("drop_busy_low", LINE_W'(bus.busy), '0);

    // Randomized mixed traffic on disjoint I and D regions
    strict_cmd = 1'b0;
    rand_phase = 1'b1;
    lat_min    = 0;
    lat_max    = 3;
    fork
      begin
        for (int t = 0; t < 40; t++) begin
          int gap;
          i_request(32'h1000_0000 + (32'($urandom_range(7, 0)) << 5));
          gap = $urandom_range(2, 0);
          if (gap > 0) begin
            i_release();
            repeat (gap - 1) @(posedge clk);
          end
        end
        i_release();
      end
      begin
        for (int t = 0; t < 40; t++) begin
          int gap;
          d_request(1'($urandom_range(1, 0)),
                    32'h2000_0000 + (32'($urandom_range(7, 0)) << 5), rand_line());
          gap = $urandom_range(2, 0);
          if (gap > 0) begin
            d_release();
            repeat (gap - 1) @(posedge clk);
          end
        end
        d_release();
      end
    join
    rand_phase = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  initial begin : main
    rst = 1'b0;
    bus.icache_read  = 1'b0;
    bus.icache_addr  = '0;
    bus.dcache_read  = 1'b0;
    bus.dcache_write = 1'b0;
    bus.dcache_addr  = '0;
    bus.dcache_wdata = '0;
    #12;
    check_output("init_busy", LINE_W'(bus.busy), '0);
    check_output("init_pmem_read", LINE_W'(bus.pmem_read), '0);
    check_output("init_pmem_write", LINE_W'(bus.pmem_write), '0);
    check_output("init_icache_resp", LINE_W'(bus.icache_resp), '0);
    check_output("init_dcache_resp", LINE_W'(bus.dcache_resp), '0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    strict_cmd = 1'b1;
    apply_stimulus();
    check_output("i_exp_drained", LINE_W'(i_exp.size()), '0);
    check_output("d_exp_drained", LINE_W'(d_exp.size()), '0);
    check_output("cmd_exp_drained", LINE_W'(cmd_exp.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
